// File: rtl/mont_sched_pkg.sv
// Shared types and default sizing for the Montgomery reducer scheduler.
package mont_sched_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned LAT_DEF        = 20;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned DATA_W         = 64;
  // Wide enough for any practical requester count; the top narrows it to ID_W.
  localparam int unsigned RSP_ID_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [DATA_W-1:0]   data;
  } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; output data reads 0 while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic                       rd_valid_o,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_c, pop_c;

  assign push_c     = wr_en_i && (count_q < CNT_W'(DEPTH));
  assign pop_c      = rd_en_i && (count_q != '0);
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mont_reduce_sched.sv
// Round-robin issue of requester operands into a shared fixed-latency Montgomery
// reducer, with tag tracking, credit-gated response FIFO and drained config updates.
module mont_reduce_sched
  import mont_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned LAT        = LAT_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cfg_we_i,
  input  logic [DATA_W-1:0]               cfg_m_i,
  input  logic [DATA_W-1:0]               cfg_minv_i,
  output logic                            cfg_ready_o,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_x_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            red_start_o,
  output logic [DATA_W-1:0]               red_x_o,
  output logic [DATA_W-1:0]               red_m_o,
  output logic [DATA_W-1:0]               red_minv_o,
  input  logic                            red_valid_i,
  input  logic [DATA_W-1:0]               red_result_i,
  output logic                            rsp_valid_o,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic [DATA_W-1:0]               rsp_data_o,
  input  logic                            rsp_ready_i,
  output logic                            err_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  state_t                state_q, state_d;
  logic                  cfg_ready_q;
  logic                  load_act_c, load_pend_c, apply_pend_c;
  logic [DATA_W-1:0]     act_m_q, act_minv_q, pend_m_q, pend_minv_q;
  logic [ID_W-1:0]       last_grant_q, cand_c, gnt_id_c;
  logic                  found_c, can_issue_c, gnt_any_c, dec_c, push_c;
  logic [CNT_W-1:0]      inflight_q, fifo_count_c;
  logic [SUM_W-1:0]      credit_sum_c;
  logic [LAT:0]          tag_v_q;
  logic [LAT:0][ID_W-1:0] tag_id_q;
  logic                  red_start_q, err_q;
  logic [DATA_W-1:0]     red_x_q, red_m_q, red_minv_q;
  rsp_t                  wr_rsp_c, rd_rsp_c;

  // Mode FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= (state_d != DRAIN);
    end
  end

  // Mode FSM: next state and config load strobes.
  always_comb begin
    state_d      = state_q;
    load_act_c   = 1'b0;
    load_pend_c  = 1'b0;
    apply_pend_c = 1'b0;
    case (state_q)
      IDLE: if (cfg_we_i) begin
        load_act_c = 1'b1;
        state_d    = RUN;
      end
      RUN: if (cfg_we_i) begin
        load_pend_c = 1'b1;
        state_d     = DRAIN;
      end
      DRAIN: if (inflight_q == '0) begin
        apply_pend_c = 1'b1;
        state_d      = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_m_q     <= '0;
      act_minv_q  <= '0;
      pend_m_q    <= '0;
      pend_minv_q <= '0;
    end else begin
      if (load_act_c) begin
        act_m_q    <= cfg_m_i;
        act_minv_q <= cfg_minv_i;
      end else if (apply_pend_c) begin
        act_m_q    <= pend_m_q;
        act_minv_q <= pend_minv_q;
      end
      if (load_pend_c) begin
        pend_m_q    <= cfg_m_i;
        pend_minv_q <= cfg_minv_i;
      end
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_c  = 1'b0;
    gnt_id_c = '0;
    cand_c   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (!found_c && req_valid_i[cand_c]) begin
        found_c  = 1'b1;
        gnt_id_c = cand_c;
      end
    end
  end

  // Credits cover both in-flight ops and buffered responses so the FIFO cannot overflow.
  assign credit_sum_c = SUM_W'(inflight_q) + SUM_W'(fifo_count_c);
  assign can_issue_c  = (state_q == RUN) && (credit_sum_c < SUM_W'(FIFO_DEPTH));
  assign gnt_any_c    = found_c && can_issue_c;
  assign req_ready_o  = gnt_any_c ? (NUM_REQ'(1) << gnt_id_c) : '0;
  assign dec_c        = red_valid_i && (inflight_q != '0);
  assign push_c       = red_valid_i && tag_v_q[LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      inflight_q   <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      red_start_q  <= 1'b0;
      red_x_q      <= '0;
      red_m_q      <= '0;
      red_minv_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      red_start_q <= gnt_any_c;
      if (gnt_any_c) begin
        last_grant_q <= gnt_id_c;
        red_x_q      <= req_x_i[gnt_id_c];
        red_m_q      <= act_m_q;
        red_minv_q   <= act_minv_q;
      end
      case ({gnt_any_c, dec_c})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      // Stage 0 loads with the operand registers; stage LAT lines up with red_valid_i.
      tag_v_q  <= {tag_v_q[LAT-1:0], gnt_any_c};
      tag_id_q <= {tag_id_q[LAT-1:0], gnt_id_c};
      err_q    <= err_q | (red_valid_i ^ tag_v_q[LAT]);
    end
  end

  assign wr_rsp_c = '{id: RSP_ID_W'(tag_id_q[LAT]), data: red_result_i};

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (push_c),
    .wr_data_i  (wr_rsp_c),
    .rd_en_i    (rsp_ready_i),
    .rd_valid_o (rsp_valid_o),
    .rd_data_o  (rd_rsp_c),
    .count_o    (fifo_count_c)
  );

  assign rsp_id_o    = ID_W'(rd_rsp_c.id);
  assign rsp_data_o  = rd_rsp_c.data;
  assign cfg_ready_o = cfg_ready_q;
  assign red_start_o = red_start_q;
  assign red_x_o     = red_x_q;
  assign red_m_o     = red_m_q;
  assign red_minv_o  = red_minv_q;
  assign err_o       = err_q;

endmodule
